// File: rtl/ft245_fifo_ctrl.sv
// FT245-style asynchronous FIFO master.
// Turns device bytes into a valid/ready RX stream and a valid/ready TX stream into
// device writes, pacing RD_n/WR_n with per-phase cycle counts and keeping the shared
// bus released whenever a write is not in progress.
`timescale 1ns/1ps
module ft245_fifo_ctrl #(
  parameter int unsigned RD_LOW_CYC   = 4,
  parameter int unsigned RD_HIGH_CYC  = 4,
  parameter int unsigned WR_SETUP_CYC = 2,
  parameter int unsigned WR_LOW_CYC   = 4,
  parameter int unsigned WR_HIGH_CYC  = 4
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iFIFO_RXF_n,
  input  logic       iFIFO_TXE_n,
  output logic       oFIFO_RD_n,
  output logic       oFIFO_WR_n,
  inout  wire  [7:0] ioFIFO_DATA,
  output logic [7:0] oRX_DATA,
  output logic       oRX_VALID,
  input  logic       iRX_READY,
  input  logic [7:0] iTX_DATA,
  input  logic       iTX_VALID,
  output logic       oTX_READY,
  output logic       oBUSY
);

  // Per-phase reload values for the 4-bit phase counter.
  localparam logic [3:0] RD_LOW_LD   = RD_LOW_CYC[3:0];
  localparam logic [3:0] RD_HIGH_LD  = RD_HIGH_CYC[3:0];
  localparam logic [3:0] WR_SETUP_LD = WR_SETUP_CYC[3:0];
  localparam logic [3:0] WR_LOW_LD   = WR_LOW_CYC[3:0];
  localparam logic [3:0] WR_HIGH_LD  = WR_HIGH_CYC[3:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LOW,
    S_RD_HIGH,
    S_WR_SETUP,
    S_WR_LOW,
    S_WR_HIGH
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  logic       rxf_meta;
  logic       rxf_s;
  logic       txe_meta;
  logic       txe_s;

  logic       last_rd;
  logic       grant_rd;
  logic       grant_wr;
  logic       rd_ok;
  logic       wr_ok;
  logic       rd_sample;

  logic       rd_n;
  logic       wr_n;
  logic       bus_oe;
  logic [7:0] wr_data;

  logic [7:0] rx_data;
  logic       rx_valid;

  logic [7:0] tx_hold;
  logic       tx_full;
  logic       tx_full_next;
  logic       tx_ready;
  logic       tx_capture;

  // Two-flop synchronizers; they come out of reset reporting "not ready".
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
    end else begin
      rxf_meta <= iFIFO_RXF_n;
      rxf_s    <= rxf_meta;
      txe_meta <= iFIFO_TXE_n;
      txe_s    <= txe_meta;
    end
  end

  // A read may start only when the device has data and the RX slot is empty;
  // a write only when the device has room and a TX byte is held.
  assign rd_ok = ~rxf_s & ~rx_valid;
  assign wr_ok = ~txe_s & tx_full;

  // Data is sampled in the last low cycle of the read strobe.
  assign rd_sample = (state == S_RD_LOW) && (cnt == 4'd1);

  // Next-state and phase counter: each phase reloads on entry and exits at count 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_ok && (!wr_ok || !last_rd)) begin
          state_next = S_RD_LOW;
          cnt_next   = RD_LOW_LD;
          grant_rd   = 1'b1;
        end else if (wr_ok) begin
          state_next = S_WR_SETUP;
          cnt_next   = WR_SETUP_LD;
          grant_wr   = 1'b1;
        end
      end
      S_RD_LOW: begin
        if (cnt == 4'd1) begin
          state_next = S_RD_HIGH;
          cnt_next   = RD_HIGH_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_RD_HIGH: begin
        if (cnt == 4'd1) begin
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_WR_SETUP: begin
        if (cnt == 4'd1) begin
          state_next = S_WR_LOW;
          cnt_next   = WR_LOW_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_WR_LOW: begin
        if (cnt == 4'd1) begin
          state_next = S_WR_HIGH;
          cnt_next   = WR_HIGH_LD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_WR_HIGH: begin
        if (cnt == 4'd1) begin
          state_next = S_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State register plus strobes and bus enable registered from the next state,
  // so the pins change cleanly on the edge that enters each phase.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      last_rd <= 1'b0;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      bus_oe  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (grant_rd) begin
        last_rd <= 1'b1;
      end else if (grant_wr) begin
        last_rd <= 1'b0;
      end
      rd_n   <= (state_next != S_RD_LOW);
      wr_n   <= (state_next != S_WR_LOW);
      bus_oe <= (state_next == S_WR_SETUP) || (state_next == S_WR_LOW);
    end
  end

  // RX holding register: loaded at the end of the read strobe, emptied on handshake.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      if (rx_valid && iRX_READY) begin
        rx_valid <= 1'b0;
      end
      if (rd_sample) begin
        rx_data  <= ioFIFO_DATA;
        rx_valid <= 1'b1;
      end
    end
  end

  // The held byte is handed to the bus register when a write is granted, freeing
  // the TX slot; a new byte arriving during the write cannot disturb the bus.
  assign tx_capture   = iTX_VALID & tx_ready;
  assign tx_full_next = grant_wr ? 1'b0 : (tx_capture ? 1'b1 : tx_full);

  // TX holding register and its registered ready flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      tx_hold  <= 8'h00;
      tx_full  <= 1'b0;
      tx_ready <= 1'b0;
      wr_data  <= 8'h00;
    end else begin
      tx_full  <= tx_full_next;
      tx_ready <= ~tx_full_next;
      if (tx_capture) begin
        tx_hold <= iTX_DATA;
      end
      if (grant_wr) begin
        wr_data <= tx_hold;
      end
    end
  end

  assign ioFIFO_DATA = bus_oe ? wr_data : 8'hzz;
  assign oFIFO_RD_n  = rd_n;
  assign oFIFO_WR_n  = wr_n;
  assign oRX_DATA    = rx_data;
  assign oRX_VALID   = rx_valid;
  assign oTX_READY   = tx_ready;
  assign oBUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_ft245_fifo_ctrl.sv
// Directed bench for ft245_fifo_ctrl with a small FT245 responder model.
`timescale 1ns/1ps
module tb_ft245_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txe_n = 1'b1;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        rxf_n;
  wire  [7:0] fifo_data;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Responder state: byte table, read pointer, bytes still available.
  logic [7:0] rx_table [0:15];
  logic [3:0] rd_idx = 4'd0;
  int         avail = 0;
  logic       in_read = 1'b0;
  int         rd_count = 0;

  logic [7:0] rx_got[$];
  logic [7:0] wr_log[$];
  logic [7:0] strobe_seq[$];

  logic       mon_en = 1'b0;
  int         low_len = 0;
  int         high_len = 0;
  logic       seen_read = 1'b0;
  logic [7:0] bus_p1 = 8'hFF;
  logic [7:0] bus_p2 = 8'hFF;
  logic       wr_prev = 1'b1;

  ft245_fifo_ctrl dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iFIFO_RXF_n (rxf_n),
    .iFIFO_TXE_n (txe_n),
    .oFIFO_RD_n  (rd_n),
    .oFIFO_WR_n  (wr_n),
    .ioFIFO_DATA (fifo_data),
    .oRX_DATA    (rx_data),
    .oRX_VALID   (rx_valid),
    .iRX_READY   (rx_ready),
    .iTX_DATA    (tx_data),
    .iTX_VALID   (tx_valid),
    .oTX_READY   (tx_ready),
    .oBUSY       (busy)
  );

  always #5 clk = ~clk;

  // Released bus floats high so an undriven bus reads 0xFF.
  pullup (fifo_data);

  assign rxf_n     = (avail == 0);
  assign fifo_data = (!rd_n) ? rx_table[rd_idx] : 8'hzz;

  // Responder: note each read strobe start.
  always @(negedge rd_n) begin
    if (!rst) begin
      in_read = 1'b1;
      rd_count++;
      strobe_seq.push_back(8'h52);
    end
  end

  // Responder: a completed (or aborted) read consumes one byte.
  always @(posedge rd_n) begin
    if (in_read) begin
      in_read = 1'b0;
      if (rd_idx != 4'd15) rd_idx = rd_idx + 4'd1;
      if (avail > 0) avail--;
    end
  end

  // Responder: latch the bus on the falling edge of WR_n.
  always @(negedge wr_n) begin
    if (!rst) begin
      wr_log.push_back(fifo_data);
      strobe_seq.push_back(8'h57);
    end
  end

  // RX consumer: a byte is accepted when valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (rx_valid && rx_ready && !rst) rx_got.push_back(rx_data);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pin-level protocol monitor, sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!mon_en) begin
      low_len   = 0;
      high_len  = 0;
      seen_read = 1'b0;
    end else begin
      if (!rd_n || !wr_n) checkOutput("strobe_excl", 32'(rd_n | wr_n), 32'd1);
      if (!rd_n) begin
        checkOutput("rd_bus", 32'(fifo_data), 32'(rx_table[rd_idx]));
        if (low_len == 0 && seen_read) checkOutput("rd_high_gap", 32'(high_len >= 4), 32'd1);
        low_len++;
      end else begin
        if (low_len != 0) begin
          checkOutput("rd_low_len", 32'(low_len), 32'd4);
          seen_read = 1'b1;
          high_len  = 0;
        end
        low_len = 0;
        high_len++;
      end
      if (wr_prev && !wr_n)
        checkOutput("wr_bus_setup", 32'((bus_p1 == fifo_data) && (bus_p2 == fifo_data)), 32'd1);
      if (!wr_prev && wr_n) checkOutput("wr_bus_release", 32'(fifo_data), 32'hFF);
      if (rd_n && wr_n && !busy) checkOutput("bus_idle", 32'(fifo_data), 32'hFF);
    end
    bus_p2  = bus_p1;
    bus_p1  = fifo_data;
    wr_prev = wr_n;
  end

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic applyStimulus(input int n_avail, input logic txe, input logic ready);
    avail    = n_avail;
    txe_n    = txe;
    rx_ready = ready;
  endtask

  task automatic sendByte(input logic [7:0] d);
    int n;
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("tx_ready_wait", 32'(n < 50), 32'd1);
    stepCycle();
    tx_valid = 1'b0;
  endtask

  function automatic logic [7:0] gotAt(input int i);
    return (i < rx_got.size()) ? rx_got[i] : 8'h00;
  endfunction

  function automatic logic [7:0] wrAt(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 8'h00;
  endfunction

  function automatic logic [7:0] seqAt(input int i);
    return (i < strobe_seq.size()) ? strobe_seq[i] : 8'h00;
  endfunction

  initial begin
    int n;
    int rc0;
    int wl0;
    for (int i = 0; i < 16; i++) rx_table[i] = 8'(17 * (i + 1));

    // Reset state.
    rst = 1'b1;
    stepCycles(3);
    checkOutput("rst_rd_n", 32'(rd_n), 32'd1);
    checkOutput("rst_wr_n", 32'(wr_n), 32'd1);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_bus", 32'(fifo_data), 32'hFF);
    rst = 1'b0;
    stepCycle();
    checkOutput("rel_tx_ready", 32'(tx_ready), 32'd1);
    mon_en = 1'b1;

    // Three bytes from the device, consumer always ready.
    applyStimulus(3, 1'b1, 1'b1);
    n = 0;
    while (rd_n && n < 20) begin stepCycle(); n++; end
    checkOutput("rxf_to_rd_lat", 32'(n), 32'd3);
    n = 0;
    while (rx_got.size() < 3 && n < 100) begin stepCycle(); n++; end
    checkOutput("rx3_wait", 32'(n < 100), 32'd1);
    stepCycles(20);
    checkOutput("rx_count", 32'(rx_got.size()), 32'd3);
    checkOutput("rx_byte0", 32'(gotAt(0)), 32'h11);
    checkOutput("rx_byte1", 32'(gotAt(1)), 32'h22);
    checkOutput("rx_byte2", 32'(gotAt(2)), 32'h33);

    // Two writes with the device accepting.
    wr_log.delete();
    applyStimulus(0, 1'b0, 1'b1);
    sendByte(8'hA5);
    sendByte(8'h5A);
    n = 0;
    while (wr_log.size() < 2 && n < 100) begin stepCycle(); n++; end
    checkOutput("wr2_wait", 32'(n < 100), 32'd1);
    stepCycles(15);
    checkOutput("wr_count", 32'(wr_log.size()), 32'd2);
    checkOutput("wr_byte0", 32'(wrAt(0)), 32'hA5);
    checkOutput("wr_byte1", 32'(wrAt(1)), 32'h5A);

    // Read and write both pending: grants alternate starting with a read.
    wr_log.delete();
    rx_got.delete();
    strobe_seq.delete();
    applyStimulus(0, 1'b1, 1'b1);
    stepCycles(4);
    sendByte(8'h3C);
    stepCycles(2);
    applyStimulus(2, 1'b0, 1'b1);
    sendByte(8'hC3);
    n = 0;
    while (strobe_seq.size() < 4 && n < 200) begin stepCycle(); n++; end
    checkOutput("tie_wait", 32'(n < 200), 32'd1);
    stepCycles(15);
    checkOutput("tie_order", {seqAt(0), seqAt(1), seqAt(2), seqAt(3)}, 32'h52575257);
    checkOutput("tie_wr0", 32'(wrAt(0)), 32'h3C);
    checkOutput("tie_wr1", 32'(wrAt(1)), 32'hC3);
    checkOutput("tie_rx0", 32'(gotAt(0)), 32'h44);
    checkOutput("tie_rx1", 32'(gotAt(1)), 32'h55);

    // Consumer stall: one read only, data held, reads resume on ready.
    stepCycles(10);
    rx_got.delete();
    applyStimulus(2, 1'b1, 1'b0);
    rc0 = rd_count;
    n = 0;
    while (!rx_valid && n < 30) begin stepCycle(); n++; end
    checkOutput("stall_valid_wait", 32'(n < 30), 32'd1);
    checkOutput("stall_data", 32'(rx_data), 32'h66);
    stepCycles(40);
    checkOutput("stall_reads", 32'(rd_count - rc0), 32'd1);
    checkOutput("stall_valid", 32'(rx_valid), 32'd1);
    checkOutput("stall_hold", 32'(rx_data), 32'h66);
    rx_ready = 1'b1;
    n = 0;
    while (rd_n && n < 20) begin stepCycle(); n++; end
    checkOutput("stall_resume", 32'((n >= 1) && (n <= 3)), 32'd1);
    n = 0;
    while (rx_got.size() < 2 && n < 50) begin stepCycle(); n++; end
    checkOutput("stall_rx0", 32'(gotAt(0)), 32'h66);
    checkOutput("stall_rx1", 32'(gotAt(1)), 32'h77);

    // Device full: the TX byte is held until TXE_n falls.
    stepCycles(20);
    wl0 = wr_log.size();
    applyStimulus(0, 1'b1, 1'b1);
    sendByte(8'hE1);
    stepCycles(20);
    checkOutput("txe_no_write", 32'(wr_log.size() - wl0), 32'd0);
    checkOutput("txe_wr_n", 32'(wr_n), 32'd1);
    checkOutput("txe_tx_ready", 32'(tx_ready), 32'd0);
    txe_n = 1'b0;
    n = 0;
    while (!busy && n < 20) begin stepCycle(); n++; end
    checkOutput("txe_to_write", 32'(n), 32'd3);
    n = 0;
    while (wr_log.size() <= wl0 && n < 30) begin stepCycle(); n++; end
    checkOutput("txe_byte", 32'(wrAt(wl0)), 32'hE1);

    // Reset during the read strobe.
    stepCycles(20);
    mon_en = 1'b0;
    applyStimulus(1, 1'b1, 1'b1);
    n = 0;
    while (rd_n && n < 20) begin stepCycle(); n++; end
    checkOutput("rdrst_wait", 32'(n < 20), 32'd1);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("rdrst_rd_n", 32'(rd_n), 32'd1);
    checkOutput("rdrst_wr_n", 32'(wr_n), 32'd1);
    checkOutput("rdrst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rdrst_bus", 32'(fifo_data), 32'hFF);
    checkOutput("rdrst_busy", 32'(busy), 32'd0);
    checkOutput("rdrst_tx_ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("rdrst_rel_ready", 32'(tx_ready), 32'd1);
    stepCycles(10);

    // Reset during the write strobe: held byte is dropped, no retry.
    applyStimulus(0, 1'b0, 1'b1);
    wl0 = wr_log.size();
    sendByte(8'hB7);
    n = 0;
    while (wr_n && n < 30) begin stepCycle(); n++; end
    checkOutput("wrrst_wait", 32'(n < 30), 32'd1);
    rst = 1'b1;
    stepCycle();
    checkOutput("wrrst_wr_n", 32'(wr_n), 32'd1);
    checkOutput("wrrst_rd_n", 32'(rd_n), 32'd1);
    checkOutput("wrrst_bus", 32'(fifo_data), 32'hFF);
    checkOutput("wrrst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("wrrst_tx_ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("wrrst_rel_ready", 32'(tx_ready), 32'd1);
    stepCycles(30);
    checkOutput("wrrst_writes", 32'(wr_log.size() - wl0), 32'd1);
    checkOutput("wrrst_byte", 32'(wrAt(wl0)), 32'hB7);
    checkOutput("wrrst_idle_wr_n", 32'(wr_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
